sd_image_loader: RTL and testbench
==================================

Name: sd_image_loader

Overview:
- Parametrised successor to the single-image SD-to-DDR3 photo loader.
- Streams one of NUM_IMG BMP images from consecutive SD-card sector regions through the SD SPI controller's read port.
- Strips the BMP header and repacks 24-bit BGR bytes into RGB565 pixel words for the DDR3 write FIFO.
- Selectable image index, runtime pixel count and an error flag for runaway sector reads.

Parameters:
- NUM_IMG, 4, number of images stored on card; IDX_W = clog2(NUM_IMG), minimum 1.
- IMG_BASE_SEC, 16400, first sector of image 0.
- IMG_STRIDE_SEC, 3000, sector distance between consecutive image starts.
- HDR_BYTES, 54, BMP header bytes skipped at image start; must be even.
- MAX_SEC, 2814, sector budget per image before abort with error.
- PIX_CNT_W, 24, width of pixel counter and pix_total.

Ports:
- clk  in  1  system clock (SD controller user clock, 50 MHz).
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle load request.
- img_idx  in  IDX_W  image to load; sampled when start is accepted.
- pix_total  in  PIX_CNT_W  pixels to emit (h_disp*v_disp); sampled when start is accepted.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of load.
- err  out  1  sticky until next accepted start: sector budget exhausted.
- sd_rd_start_en  out  1  one-cycle sector read request.
- sd_rd_sec_addr  out  32  sector address; held stable while a read is outstanding.
- sd_rd_busy  in  1  SD controller read busy.
- sd_rd_val_en  in  1  read data valid.
- sd_rd_val_data  in  16  read word; [15:8] is the earlier byte.
- frame_start  out  1  one-cycle pulse on accepted start (DDR3 wr_load).
- pix_valid  out  1  RGB565 pixel valid.
- pix_data  out  16  {R[7:3],G[7:2],B[7:3]}.

Behaviour:
- Reset values: busy, done, err, sd_rd_start_en, frame_start and pix_valid are 0; sd_rd_sec_addr and pix_data are 0; FSM is in IDLE.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, CHECK, FIN.
- IDLE: start=1 is accepted. It latches img_idx and pix_total, sets sd_rd_sec_addr = IMG_BASE_SEC + img_idx*IMG_STRIDE_SEC, clears the byte, pixel and sector counters, clears err, pulses frame_start, sets busy and moves to ISSUE.
- img_idx >= NUM_IMG: clamp to NUM_IMG-1.
- pix_total = 0: skip straight to FIN. No SD read is issued, done pulses, err = 0.
- ISSUE: pulse sd_rd_start_en for one cycle, then go to WAIT_HI.
- WAIT_HI: wait for sd_rd_busy=1, then go to WAIT_LO.
- WAIT_LO: wait for sd_rd_busy=0, then go to CHECK.
- CHECK, in priority order:
  - pixel count reached pix_total: go to FIN.
  - sector count reached MAX_SEC: set err, go to FIN.
  - otherwise: increment sd_rd_sec_addr, go to ISSUE.
- FIN: pulse done, clear busy, return to IDLE.
- Byte stream handling:
  - Each sd_rd_val_en word yields two bytes, high byte first.
  - The first HDR_BYTES bytes of the image are discarded.
  - The remaining bytes are consumed in B, G, R order. A 2-byte holding register plus phase counter (0..2) spans word boundaries, since a triple may straddle words.
  - On completing R: pix_valid=1 and pix_data updated on the next clock edge (1-cycle latency from the data word).
  - A word completes at most one pixel per cycle, so no back-pressure is needed.
- Once the pixel count equals pix_total, all further bytes (BMP padding, tail of last sector) are dropped. No pix_valid is produced.
- start while busy is ignored; counters and the FSM are unaffected.
- sd_rd_val_en while IDLE is ignored.
- Async rst mid-load aborts immediately: all outputs return to reset values.
- Sector address arithmetic is 32-bit unsigned and wraps modulo 2^32.
- The sector counter is 16 bits.

Test Plan:
- img_idx=0, pix_total=1, sector model returns 54 header bytes, then B=FF G=00 R=00 -> one sd_rd_start_en at sector 16400; exactly one pix_valid with pix_data=0x001F; done pulses; err=0.
- img_idx=2, pix_total=170 (510 data bytes; image spans sectors 22400..22401) -> sd_rd_sec_addr sequence 22400, 22401; 170 pixels; a triple straddling the sector boundary is assembled correctly; trailing bytes produce no pix_valid.
- Pixel bytes R=FF G=FF B=FF then R=80 G=40 B=20 -> pix_data 0xFFFF then 0x8204.
- pix_total=1000000 with MAX_SEC=4 (bench override) -> exactly 4 sector reads; err=1; done pulses; busy=0.
- start asserted again while busy in WAIT_LO, img_idx=3 -> ignored; addresses continue for the original image.
- rst pulsed mid-transfer, then a fresh start with img_idx=1 -> outputs at reset values during rst; new load begins at sector 19400 with pixel counter cleared.

Source files
------------

// File: rtl/sd_image_loader_if.sv
// SD read port and pixel output bundle between the image loader and its neighbours.
// master = loader side, slave = SD controller / DDR3 write FIFO side.
interface sd_image_loader_if;
  logic        sd_rd_start_en;
  logic [31:0] sd_rd_sec_addr;
  logic        sd_rd_busy;
  logic        sd_rd_val_en;
  logic [15:0] sd_rd_val_data;
  logic        frame_start;
  logic        pix_valid;
  logic [15:0] pix_data;

  modport master (
    output sd_rd_start_en, sd_rd_sec_addr, frame_start, pix_valid, pix_data,
    input  sd_rd_busy, sd_rd_val_en, sd_rd_val_data
  );

  modport slave (
    input  sd_rd_start_en, sd_rd_sec_addr, frame_start, pix_valid, pix_data,
    output sd_rd_busy, sd_rd_val_en, sd_rd_val_data
  );
endinterface

// File: rtl/sd_image_loader.sv
// Reads one BMP image from SD sectors, skips its header and repacks BGR888 into RGB565.
// Sector reads repeat until the requested pixel count is reached or the sector budget runs out.
module sd_image_loader #(
  parameter int NUM_IMG        = 4,
  parameter int IMG_BASE_SEC   = 16400,
  parameter int IMG_STRIDE_SEC = 3000,
  parameter int HDR_BYTES      = 54,
  parameter int MAX_SEC        = 2814,
  parameter int PIX_CNT_W      = 24,
  localparam int IDX_W         = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IDX_W-1:0]     img_idx,
  input  logic [PIX_CNT_W-1:0] pix_total,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  sd_image_loader_if.master    sd
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, CHECK, FIN} state_t;

  state_t               state_reg, state_next;
  logic [31:0]          sec_addr_reg;
  logic [15:0]          sec_cnt_reg;
  logic [15:0]          hdr_cnt_reg;
  logic [PIX_CNT_W-1:0] pix_cnt_reg, pix_total_reg;
  logic [1:0]           phase_reg;
  logic [7:0]           hold_b_reg, hold_g_reg;
  logic                 err_reg, frame_start_reg, pix_valid_reg;
  logic [15:0]          pix_data_reg;

  logic        accept, pix_reached, budget_out, word_ok, in_hdr, pix_fire;
  logic [31:0] idx_clamped, base_addr;
  logic [7:0]  byte_hi, byte_lo, r_byte, g_byte, b_byte;

  assign accept      = (state_reg == IDLE) && start;
  assign pix_reached = (pix_cnt_reg == pix_total_reg);
  assign budget_out  = (sec_cnt_reg == 16'(MAX_SEC));
  assign word_ok     = sd.sd_rd_val_en && (state_reg != IDLE);
  assign in_hdr      = (hdr_cnt_reg < 16'(HDR_BYTES));
  assign byte_hi     = sd.sd_rd_val_data[15:8];
  assign byte_lo     = sd.sd_rd_val_data[7:0];

  always_comb begin
    idx_clamped = 32'(img_idx);
    if (idx_clamped >= 32'(NUM_IMG))
      idx_clamped = 32'(NUM_IMG - 1);
    base_addr = 32'(IMG_BASE_SEC) + idx_clamped * 32'(IMG_STRIDE_SEC);
  end

  // Phase = bytes of the current B,G,R triple already held when the word arrives.
  always_comb begin
    pix_fire = 1'b0;
    r_byte   = 8'h00;
    g_byte   = 8'h00;
    b_byte   = 8'h00;
    if (word_ok && !in_hdr && !pix_reached) begin
      case (phase_reg)
        2'd1: begin
          b_byte   = hold_b_reg;
          g_byte   = byte_hi;
          r_byte   = byte_lo;
          pix_fire = 1'b1;
        end
        2'd2: begin
          b_byte   = hold_b_reg;
          g_byte   = hold_g_reg;
          r_byte   = byte_hi;
          pix_fire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next        = state_reg;
    busy              = (state_reg != IDLE);
    done              = (state_reg == FIN);
    sd.sd_rd_start_en = (state_reg == ISSUE);
    case (state_reg)
      IDLE:    if (start) state_next = (pix_total == '0) ? FIN : ISSUE;
      ISSUE:   state_next = WAIT_HI;
      WAIT_HI: if (sd.sd_rd_busy) state_next = WAIT_LO;
      WAIT_LO: if (!sd.sd_rd_busy) state_next = CHECK;
      CHECK:   state_next = (pix_reached || budget_out) ? FIN : ISSUE;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_addr_reg    <= '0;
      sec_cnt_reg     <= '0;
      hdr_cnt_reg     <= '0;
      pix_cnt_reg     <= '0;
      pix_total_reg   <= '0;
      phase_reg       <= '0;
      hold_b_reg      <= '0;
      hold_g_reg      <= '0;
      err_reg         <= 1'b0;
      frame_start_reg <= 1'b0;
      pix_valid_reg   <= 1'b0;
      pix_data_reg    <= '0;
    end else begin
      frame_start_reg <= accept;
      pix_valid_reg   <= 1'b0;
      if (accept) begin
        sec_addr_reg  <= base_addr;
        sec_cnt_reg   <= '0;
        hdr_cnt_reg   <= '0;
        pix_cnt_reg   <= '0;
        pix_total_reg <= pix_total;
        phase_reg     <= '0;
        err_reg       <= 1'b0;
      end else begin
        if (state_reg == ISSUE)
          sec_cnt_reg <= sec_cnt_reg + 16'd1;
        if (state_reg == CHECK && !pix_reached) begin
          if (budget_out)
            err_reg <= 1'b1;
          else
            sec_addr_reg <= sec_addr_reg + 32'd1;
        end
        // Header length is even, so it always ends on a word boundary.
        if (word_ok && in_hdr) begin
          hdr_cnt_reg <= hdr_cnt_reg + 16'd2;
        end else if (word_ok && !pix_reached) begin
          case (phase_reg)
            2'd0: begin
              hold_b_reg <= byte_hi;
              hold_g_reg <= byte_lo;
              phase_reg  <= 2'd2;
            end
            2'd1:    phase_reg <= 2'd0;
            default: begin
              hold_b_reg <= byte_lo;
              phase_reg  <= 2'd1;
            end
          endcase
        end
        if (pix_fire) begin
          pix_cnt_reg   <= pix_cnt_reg + 1'b1;
          pix_valid_reg <= 1'b1;
          pix_data_reg  <= {r_byte[7:3], g_byte[7:2], b_byte[7:3]};
        end
      end
    end
  end

  assign err               = err_reg;
  assign sd.sd_rd_sec_addr = sec_addr_reg;
  assign sd.frame_start    = frame_start_reg;
  assign sd.pix_valid      = pix_valid_reg;
  assign sd.pix_data       = pix_data_reg;

endmodule

// File: tb/tb_sd_image_loader.sv
// Directed bench for sd_image_loader: a sector model serves BMP bytes, loads are table-driven,
// and start-while-busy and mid-load reset are hand-written sequences.
module tb_sd_image_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  img_idx = '0;
  logic [23:0] pix_total = '0;
  logic        busy, done, err;

  sd_image_loader_if sd_bus();

  sd_image_loader #(.MAX_SEC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .img_idx(img_idx), .pix_total(pix_total),
    .busy(busy), .done(done), .err(err), .sd(sd_bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  data_mem [0:4095];
  int          data_len = 0;
  int          cur_base = 16400;
  logic [31:0] addr_log [$];
  logic [15:0] pix_log  [$];
  int          done_cnt = 0;

  typedef struct {
    int          idx;
    int          total;
    int          mode;       // 0: six literal bytes, 1: 510-byte pattern, 2: long pattern
    logic [47:0] lit;
    int          exp_addr;
    int          exp_reads;
    int          exp_npix;
    logic [15:0] exp_p0;
    logic [15:0] exp_p1;
    logic        exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] img_byte(input int off);
    if (off < 54) return 8'h5A;
    if (off - 54 < data_len) return data_mem[off - 54];
    return 8'hEE;
  endfunction

  function automatic logic [15:0] rgb565(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  task automatic set_pattern(input int len);
    for (int k = 0; k < 4096; k++) data_mem[k] = 8'((k * 7 + 3) & 255);
    data_len = len;
  endtask

  task automatic set_literal(input logic [47:0] lit);
    for (int k = 0; k < 6; k++) data_mem[k] = lit[47 - 8*k -: 8];
    data_len = 6;
  endtask

  // Sector model: busy rises one cycle after the request, 256 words follow, busy falls.
  initial begin
    sd_bus.sd_rd_busy     = 1'b0;
    sd_bus.sd_rd_val_en   = 1'b0;
    sd_bus.sd_rd_val_data = '0;
    forever begin
      @(negedge clk);
      if (!rst && sd_bus.sd_rd_start_en) begin
        logic [31:0] addr;
        addr = sd_bus.sd_rd_sec_addr;
        addr_log.push_back(addr);
        @(negedge clk);
        sd_bus.sd_rd_busy = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 256; w++) begin
          if (rst) break;
          sd_bus.sd_rd_val_en   = 1'b1;
          sd_bus.sd_rd_val_data = {img_byte((int'(addr) - cur_base) * 512 + 2*w),
                                   img_byte((int'(addr) - cur_base) * 512 + 2*w + 1)};
          @(negedge clk);
        end
        sd_bus.sd_rd_val_en = 1'b0;
        if (!rst) @(negedge clk);
        sd_bus.sd_rd_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sd_bus.pix_valid) pix_log.push_back(sd_bus.pix_data);
      if (done) done_cnt++;
    end
  end

  task automatic do_start(input int idx, input int total);
    addr_log.delete();
    pix_log.delete();
    done_cnt = 0;
    @(negedge clk);
    start     = 1'b1;
    img_idx   = 2'(idx);
    pix_total = 24'(total);
    @(negedge clk);
    start = 1'b0;
    chk("frame_start", 32'(sd_bus.frame_start), 32'd1);
    chk("busy_on_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (done_cnt == 0 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic check_pixels(input string name);
    int bad;
    bad = 0;
    for (int p = 0; p < pix_log.size(); p++)
      if (pix_log[p] !== rgb565(img_byte(54 + 3*p + 2), img_byte(54 + 3*p + 1), img_byte(54 + 3*p))) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    vecs[0] = '{0, 1,       0, 48'hFF0000_000000, 16400, 1, 1,   16'h001F, 16'h0000, 1'b0};
    vecs[1] = '{3, 2,       0, 48'hFFFFFF_204080, 25400, 1, 2,   16'hFFFF, 16'h8204, 1'b0};
    vecs[2] = '{2, 170,     1, 48'h0,             22400, 2, 170, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{0, 1000000, 2, 48'h0,             16400, 4, 664, 16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{1, 0,       0, 48'h0,             19400, 0, 0,   16'h0000, 16'h0000, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_start_en", 32'(sd_bus.sd_rd_start_en), 32'd0);
    chk("rst_addr", sd_bus.sd_rd_sec_addr, 32'd0);
    chk("rst_pix", {15'd0, sd_bus.pix_valid, sd_bus.pix_data}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].mode == 0) set_literal(vecs[v].lit);
      else if (vecs[v].mode == 1) set_pattern(510);
      else set_pattern(4096);
      cur_base = vecs[v].exp_addr;
      do_start(vecs[v].idx, vecs[v].total);
      wait_done();
      $display("load %0d: idx=%0d total=%0d reads=%0d pixels=%0d err=%0d",
               v, vecs[v].idx, vecs[v].total, addr_log.size(), pix_log.size(), err);
      chk("reads", 32'(addr_log.size()), 32'(vecs[v].exp_reads));
      for (int i = 0; i < addr_log.size(); i++)
        chk("sec_addr", addr_log[i], 32'(vecs[v].exp_addr + i));
      chk("npix", 32'(pix_log.size()), 32'(vecs[v].exp_npix));
      chk("err", 32'(err), 32'(vecs[v].exp_err));
      check_pixels("pix_model");
      if (vecs[v].mode == 0 && pix_log.size() >= 1) chk("pix0", 32'(pix_log[0]), 32'(vecs[v].exp_p0));
      if (vecs[v].mode == 0 && pix_log.size() >= 2) chk("pix1", 32'(pix_log[1]), 32'(vecs[v].exp_p1));
    end

    // start while busy must not disturb the running load
    set_pattern(510);
    cur_base = 16400;
    do_start(0, 170);
    begin
      int c;
      c = 0;
      while (!sd_bus.sd_rd_busy && c < 100) begin
        @(negedge clk);
        c++;
      end
      chk("ign_wait_busy", 32'(sd_bus.sd_rd_busy), 32'd1);
    end
    @(negedge clk);
    start = 1'b1; img_idx = 2'd3; pix_total = 24'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    $display("load ignore-start: reads=%0d pixels=%0d", addr_log.size(), pix_log.size());
    chk("ign_reads", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      chk("ign_addr0", addr_log[0], 32'd16400);
      chk("ign_addr1", addr_log[1], 32'd16401);
    end
    chk("ign_npix", 32'(pix_log.size()), 32'd170);
    check_pixels("ign_pix_model");

    // reset in the middle of a transfer, then a fresh load
    set_pattern(510);
    cur_base = 22400;
    do_start(2, 170);
    begin
      int c;
      c = 0;
      while (pix_log.size() < 10 && c < 2000) begin
        @(negedge clk);
        c++;
      end
      chk("mid_pixels_seen", 32'(pix_log.size() >= 10), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err_done", {30'd0, err, done}, 32'd0);
    chk("mid_rst_start_en", 32'(sd_bus.sd_rd_start_en), 32'd0);
    chk("mid_rst_frame", 32'(sd_bus.frame_start), 32'd0);
    chk("mid_rst_addr", sd_bus.sd_rd_sec_addr, 32'd0);
    chk("mid_rst_pix", {15'd0, sd_bus.pix_valid, sd_bus.pix_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    set_literal(48'hFF0000_000000);
    cur_base = 19400;
    do_start(1, 1);
    wait_done();
    $display("load after-reset: reads=%0d pixels=%0d", addr_log.size(), pix_log.size());
    chk("rr_reads", 32'(addr_log.size()), 32'd1);
    if (addr_log.size() >= 1) chk("rr_addr", addr_log[0], 32'd19400);
    chk("rr_npix", 32'(pix_log.size()), 32'd1);
    if (pix_log.size() >= 1) chk("rr_pix0", 32'(pix_log[0]), 32'h001F);
    chk("rr_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
